bcd2bin_seq: RTL

Sequential BCD-to-binary converter. It is the inverse of the combinational binary-to-BCD encoder already in the design.
- Uses reverse double dabble: shift right, then subtract 3 from every BCD digit >= 8, one bit per clock.
- Converts a packed D-digit BCD word into a W-bit binary value.
- Sits behind keypad/display-entry logic, turning decimal user input back into binary operands for the datapath.
- Fixed latency, start/done handshake.

---
 rtl/bcd2bin_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble, one bit per clock.
// Latency: Start sampled at edge k -> Done high in the cycle after edge k+W; one conversion per W+1 cycles.
// Backpressure: none; Start is only accepted in IDLE or DONE, and is ignored while Busy.
//
// Ports:
//   Clk    rising-edge clock
//   Rst    asynchronous reset, active-high
//   Start  request conversion of Bcd (sampled in IDLE or DONE only)
//   Bcd    packed D-digit BCD operand, ones digit in [3:0]
//   Busy   high while iterating (SHIFT state)
//   Done   one-cycle pulse when Bin/Err are updated
//   Bin    W-bit binary result, held until the next completion
//   Err    invalid-digit flag for the last conversion
//
// Optional feature macro: BCD2BIN_CHECK_EN
//   defined   -> operands with any nibble > 9 complete with Err=1, Bin=0
//   undefined -> no digit checking, Err is constant 0
module bcd2bin_seq #(
    parameter int D = 8,
    parameter int W = 27
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Start,
    input  logic [4*D-1:0] Bcd,
    output logic           Busy,
    output logic           Done,
    output logic [W-1:0]   Bin,
    output logic           Err
);

    localparam int N  = 4 * D + W;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    // Work register layout: {digits[4*D-1:0], bin_acc[W-1:0]}
    logic [N-1:0]   work_q, work_d;
    logic [W-1:0]   bin_q, bin_d;
    logic [N-1:0]   stepped;
    logic           accept;
    logic           last_iter;

    // A new operand can be taken when idle or in the single DONE cycle,
    // which is what allows back-to-back conversions without a bubble.
    assign accept    = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_iter = (state_q == S_SHIFT) && (cnt_q == CW'(1));

    // One reverse double-dabble step: shift right, then correct every digit
    // that came out >= 8. Bit 3 set is exactly ">= 8" for a 4-bit field, and
    // 8..15 - 3 stays within 4 bits, so no borrow crosses a digit boundary.
    always_comb begin
        logic [N-1:0] shifted;
        shifted = {1'b0, work_q[N-1:1]};
        stepped = shifted;
        for (int i = 0; i < D; i++) begin
            if (shifted[W + 4*i + 3]) begin
                stepped[W + 4*i +: 4] = shifted[W + 4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD2BIN_CHECK_EN
    logic inv_q, inv_d;
    logic err_q, err_d;
    logic bad_nibble;

    // A nibble is invalid when it is 10..15: bit 3 set with bit 2 or bit 1.
    always_comb begin
        bad_nibble = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (Bcd[4*i + 3] && (Bcd[4*i + 2] || Bcd[4*i + 1])) begin
                bad_nibble = 1'b1;
            end
        end
    end
`endif

    // State register and datapath registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            bin_q   <= '0;
`ifdef BCD2BIN_CHECK_EN
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bin_q   <= bin_d;
`ifdef BCD2BIN_CHECK_EN
            inv_q   <= inv_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = Start ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: load on accept, iterate in SHIFT, publish on the
    // final iteration so Bin is valid in the same cycle that Done is high.
    always_comb begin
        cnt_d  = cnt_q;
        work_d = work_q;
        bin_d  = bin_q;
`ifdef BCD2BIN_CHECK_EN
        inv_d  = inv_q;
        err_d  = err_q;
`endif
        if (accept) begin
            work_d = {Bcd, {W{1'b0}}};
            cnt_d  = CW'(W);
`ifdef BCD2BIN_CHECK_EN
            inv_d  = bad_nibble;
`endif
        end else if (state_q == S_SHIFT) begin
            work_d = stepped;
            cnt_d  = cnt_q - CW'(1);
            if (last_iter) begin
`ifdef BCD2BIN_CHECK_EN
                bin_d = inv_q ? {W{1'b0}} : stepped[W-1:0];
                err_d = inv_q;
`else
                bin_d = stepped[W-1:0];
`endif
            end
        end
    end

    // Outputs, decoded from the registered state
    always_comb begin
        Busy = (state_q == S_SHIFT);
        Done = (state_q == S_DONE);
        Bin  = bin_q;
`ifdef BCD2BIN_CHECK_EN
        Err  = err_q;
`else
        Err  = 1'b0;
`endif
    end

endmodule
